// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection and a
// saturating stall-cycle counter for performance monitoring.
module id_ex_pipe #(
    parameter int unsigned ALU_OP_W = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                id_valid,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [31:0]         id_operand_1,
    input  logic [31:0]         id_operand_2,
    input  logic                id_reg_read_en_1,
    input  logic                id_reg_read_en_2,
    input  logic [4:0]          id_reg_addr_1,
    input  logic [4:0]          id_reg_addr_2,
    input  logic                id_write_reg_en,
    input  logic [4:0]          id_write_reg_addr,
    input  logic                id_mem_read,

    input  logic                flush,
    input  logic                ex_stall,

    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [31:0]         ex_operand_1,
    output logic [31:0]         ex_operand_2,
    output logic                ex_write_reg_en,
    output logic [4:0]          ex_write_reg_addr,
    output logic                ex_mem_read,

    output logic                load_use_stall,
    output logic [CNT_W-1:0]    stall_cycles
);

    logic hazard;
    logic src_1_match;
    logic src_2_match;
    logic load_in_ex;

    // Load-use detection: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        load_in_ex  = ex_valid & ex_mem_read & ex_write_reg_en & (ex_write_reg_addr != 5'd0);
        src_1_match = id_reg_read_en_1 & (id_reg_addr_1 == ex_write_reg_addr);
        src_2_match = id_reg_read_en_2 & (id_reg_addr_2 == ex_write_reg_addr);
        hazard      = id_valid & load_in_ex & (src_1_match | src_2_match);
    end

    // A flush kills the ID instruction anyway, so there is nothing to hold upstream.
    assign load_use_stall = hazard & ~flush;

    // EX register update: flush > hold > load-use bubble > capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid          <= 1'b0;
            ex_alu_op         <= '0;
            ex_operand_1      <= '0;
            ex_operand_2      <= '0;
            ex_write_reg_en   <= 1'b0;
            ex_write_reg_addr <= '0;
            ex_mem_read       <= 1'b0;
        end else if (flush || (!ex_stall && hazard)) begin
            ex_valid          <= 1'b0;
            ex_alu_op         <= '0;
            ex_operand_1      <= '0;
            ex_operand_2      <= '0;
            ex_write_reg_en   <= 1'b0;
            ex_write_reg_addr <= '0;
            ex_mem_read       <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid <= id_valid;
            if (id_valid) begin
                ex_alu_op         <= id_alu_op;
                ex_operand_1      <= id_operand_1;
                ex_operand_2      <= id_operand_2;
                ex_write_reg_en   <= id_write_reg_en;
                ex_write_reg_addr <= id_write_reg_addr;
                ex_mem_read       <= id_mem_read;
            end else begin
                ex_alu_op         <= '0;
                ex_operand_1      <= '0;
                ex_operand_2      <= '0;
                ex_write_reg_en   <= 1'b0;
                ex_write_reg_addr <= '0;
                ex_mem_read       <= 1'b0;
            end
        end
    end

    // Saturating stall counter; one increment per cycle even if both stall sources are active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((load_use_stall || ex_stall) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_alu_op;
    logic [31:0] id_operand_1, id_operand_2;
    logic        id_reg_read_en_1, id_reg_read_en_2;
    logic [4:0]  id_reg_addr_1, id_reg_addr_2;
    logic        id_write_reg_en;
    logic [4:0]  id_write_reg_addr;
    logic        id_mem_read;
    logic        flush, ex_stall;

    logic        ex_valid;
    logic [7:0]  ex_alu_op;
    logic [31:0] ex_operand_1, ex_operand_2;
    logic        ex_write_reg_en;
    logic [4:0]  ex_write_reg_addr;
    logic        ex_mem_read;
    logic        load_use_stall;
    logic [31:0] stall_cycles;

    logic        s_ex_valid;
    logic [7:0]  s_ex_alu_op;
    logic [31:0] s_ex_operand_1, s_ex_operand_2;
    logic        s_ex_write_reg_en;
    logic [4:0]  s_ex_write_reg_addr;
    logic        s_ex_mem_read;
    logic        s_load_use_stall;
    logic [3:0]  s_stall_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.ALU_OP_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_operand_1(id_operand_1), .id_operand_2(id_operand_2),
        .id_reg_read_en_1(id_reg_read_en_1), .id_reg_read_en_2(id_reg_read_en_2),
        .id_reg_addr_1(id_reg_addr_1), .id_reg_addr_2(id_reg_addr_2),
        .id_write_reg_en(id_write_reg_en), .id_write_reg_addr(id_write_reg_addr),
        .id_mem_read(id_mem_read), .flush(flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_operand_1(ex_operand_1), .ex_operand_2(ex_operand_2),
        .ex_write_reg_en(ex_write_reg_en), .ex_write_reg_addr(ex_write_reg_addr),
        .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall),
        .stall_cycles(stall_cycles)
    );

    id_ex_pipe #(.ALU_OP_W(8), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_operand_1(id_operand_1), .id_operand_2(id_operand_2),
        .id_reg_read_en_1(id_reg_read_en_1), .id_reg_read_en_2(id_reg_read_en_2),
        .id_reg_addr_1(id_reg_addr_1), .id_reg_addr_2(id_reg_addr_2),
        .id_write_reg_en(id_write_reg_en), .id_write_reg_addr(id_write_reg_addr),
        .id_mem_read(id_mem_read), .flush(flush), .ex_stall(ex_stall),
        .ex_valid(s_ex_valid), .ex_alu_op(s_ex_alu_op),
        .ex_operand_1(s_ex_operand_1), .ex_operand_2(s_ex_operand_2),
        .ex_write_reg_en(s_ex_write_reg_en), .ex_write_reg_addr(s_ex_write_reg_addr),
        .ex_mem_read(s_ex_mem_read), .load_use_stall(s_load_use_stall),
        .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_alu_op = 0; id_operand_1 = 0; id_operand_2 = 0;
        id_reg_read_en_1 = 0; id_reg_read_en_2 = 0; id_reg_addr_1 = 0; id_reg_addr_2 = 0;
        id_write_reg_en = 0; id_write_reg_addr = 0; id_mem_read = 0;
    endtask

    task automatic id_instr(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic re1, input logic [4:0] r1,
                            input logic re2, input logic [4:0] r2,
                            input logic we, input logic [4:0] wd, input logic ld);
        id_valid = 1; id_alu_op = op; id_operand_1 = a; id_operand_2 = b;
        id_reg_read_en_1 = re1; id_reg_addr_1 = r1;
        id_reg_read_en_2 = re2; id_reg_addr_2 = r2;
        id_write_reg_en = we; id_write_reg_addr = wd; id_mem_read = ld;
    endtask

    initial begin
        id_clear();
        flush = 0; ex_stall = 0;
        rst = 0;
        #12;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_cnt", stall_cycles, 32'd0);
        check("rst_lus", {31'd0, load_use_stall}, 32'd0);
        @(negedge clk);
        rst = 1;

        // Plain capture
        id_instr(8'h21, 32'h11111111, 32'h22222222, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0);
        tick();
        check("cap_valid", {31'd0, ex_valid}, 32'd1);
        check("cap_op", {24'd0, ex_alu_op}, 32'h21);
        check("cap_op1", ex_operand_1, 32'h11111111);
        check("cap_op2", ex_operand_2, 32'h22222222);
        check("cap_we", {31'd0, ex_write_reg_en}, 32'd1);
        check("cap_wa", {27'd0, ex_write_reg_addr}, 32'd5);
        check("cap_ld", {31'd0, ex_mem_read}, 32'd0);
        check("cap_lus", {31'd0, load_use_stall}, 32'd0);

        // Load-use on port 2
        id_instr(8'h03, 32'h0, 32'h100, 1, 5'd1, 0, 5'd0, 1, 5'd8, 1);
        tick();
        check("ld_in_ex", {31'd0, ex_mem_read}, 32'd1);
        id_instr(8'h33, 32'hAAAA0000, 32'h0000BBBB, 1, 5'd3, 1, 5'd8, 1, 5'd9, 0);
        #1;
        check("lu_stall", {31'd0, load_use_stall}, 32'd1);
        tick(); exp_cnt++;
        check("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bub_we", {31'd0, ex_write_reg_en}, 32'd0);
        check("lu_cnt", stall_cycles, exp_cnt);
        check("lu_lus_clear", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("lu_dep_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_dep_wa", {27'd0, ex_write_reg_addr}, 32'd9);
        check("lu_dep_op2", ex_operand_2, 32'h0000BBBB);
        check("lu_dep_cnt", stall_cycles, exp_cnt);

        // Load to r0 then read r0: no hazard
        id_instr(8'h03, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd0, 1);
        tick();
        id_instr(8'h44, 32'h1, 32'h2, 1, 5'd0, 1, 5'd0, 1, 5'd10, 0);
        #1;
        check("r0_lus", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("r0_wa", {27'd0, ex_write_reg_addr}, 32'd10);

        // Read enable off with matching address: no hazard
        id_instr(8'h03, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd8, 1);
        tick();
        id_instr(8'h55, 32'h3, 32'h4, 0, 5'd8, 0, 5'd8, 1, 5'd11, 0);
        #1;
        check("ren_lus", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("ren_wa", {27'd0, ex_write_reg_addr}, 32'd11);
        check("ren_cnt", stall_cycles, exp_cnt);

        // flush beats ex_stall and hazard
        id_instr(8'h03, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd8, 1);
        tick();
        id_instr(8'h66, 32'h5, 32'h6, 1, 5'd8, 0, 5'd0, 1, 5'd12, 0);
        flush = 1; ex_stall = 1;
        #1;
        check("pri_lus", {31'd0, load_use_stall}, 32'd0);
        tick(); exp_cnt++;
        flush = 0; ex_stall = 0;
        check("pri_valid", {31'd0, ex_valid}, 32'd0);
        check("pri_ld", {31'd0, ex_mem_read}, 32'd0);
        check("pri_cnt", stall_cycles, exp_cnt);

        // ex_stall with hazard: hold wins, counter +1 once
        id_instr(8'h03, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd8, 1);
        tick();
        id_instr(8'h66, 32'h5, 32'h6, 1, 5'd8, 0, 5'd0, 1, 5'd12, 0);
        ex_stall = 1;
        #1;
        check("hold_hz_lus", {31'd0, load_use_stall}, 32'd1);
        tick(); exp_cnt++;
        ex_stall = 0;
        check("hold_hz_ld", {31'd0, ex_mem_read}, 32'd1);
        check("hold_hz_wa", {27'd0, ex_write_reg_addr}, 32'd8);
        check("hold_hz_cnt", stall_cycles, exp_cnt);
        tick(); exp_cnt++;
        check("hold_hz_bub", {31'd0, ex_valid}, 32'd0);
        tick();
        check("hold_hz_dep", {27'd0, ex_write_reg_addr}, 32'd12);

        // ex_stall alone for 3 cycles
        id_instr(8'h77, 32'hDEADBEEF, 32'hCAFEF00D, 0, 5'd0, 0, 5'd0, 1, 5'd13, 0);
        tick();
        id_instr(8'h88, 32'h12345678, 32'h9ABCDEF0, 0, 5'd0, 0, 5'd0, 1, 5'd14, 0);
        ex_stall = 1;
        repeat (3) begin tick(); exp_cnt++; end
        ex_stall = 0;
        check("frz_op", {24'd0, ex_alu_op}, 32'h77);
        check("frz_op1", ex_operand_1, 32'hDEADBEEF);
        check("frz_wa", {27'd0, ex_write_reg_addr}, 32'd13);
        check("frz_cnt", stall_cycles, exp_cnt);

        // Invalid slot loads zeros
        id_instr(8'h99, 32'h1, 32'h2, 0, 5'd0, 0, 5'd0, 1, 5'd15, 1);
        id_valid = 0;
        tick();
        check("inv_valid", {31'd0, ex_valid}, 32'd0);
        check("inv_we", {31'd0, ex_write_reg_en}, 32'd0);
        check("inv_op", {24'd0, ex_alu_op}, 32'd0);

        // Asynchronous reset mid-stall with EX valid
        id_instr(8'h21, 32'h11111111, 32'h22222222, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0);
        tick();
        ex_stall = 1;
        #2;
        rst = 0;
        #1;
        check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_op1", ex_operand_1, 32'd0);
        check("arst_cnt", stall_cycles, 32'd0);
        ex_stall = 0;
        @(negedge clk);
        rst = 1;
        exp_cnt = 0;
        id_instr(8'h42, 32'h0BADF00D, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd6, 0);
        tick();
        check("post_rst_cap", ex_operand_1, 32'h0BADF00D);
        check("post_rst_valid", {31'd0, ex_valid}, 32'd1);

        // Saturation on the 4-bit counter
        ex_stall = 1;
        repeat (15) begin tick(); exp_cnt++; end
        check("sat_15", {28'd0, s_stall_cycles}, 32'd15);
        repeat (5) begin tick(); exp_cnt++; end
        ex_stall = 0;
        check("sat_hold", {28'd0, s_stall_cycles}, 32'd15);
        check("wide_20", stall_cycles, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
